// File: rtl/morse_char_buffer_pkg.sv
// Shared code and glyph constants for the Morse display character buffer.
// All seven-segment patterns are active-low {dp,g,f,e,d,c,b,a}.
package morse_pkg;

    localparam int CODE_ERR        = 63;
    localparam int CODE_INVALID_LO = 36;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_ERR   = 8'h86;

    // Digits 0-9 and letters A-Z (10-35); mixed-case shapes where upper case is ambiguous.
    function automatic logic [7:0] font(input logic [5:0] c);
        case (c)
            6'd0:  font = 8'hC0;  6'd1:  font = 8'hF9;  6'd2:  font = 8'hA4;
            6'd3:  font = 8'hB0;  6'd4:  font = 8'h99;  6'd5:  font = 8'h92;
            6'd6:  font = 8'h82;  6'd7:  font = 8'hF8;  6'd8:  font = 8'h80;
            6'd9:  font = 8'h90;  6'd10: font = 8'h88;  6'd11: font = 8'h83;
            6'd12: font = 8'hC6;  6'd13: font = 8'hA1;  6'd14: font = 8'h86;
            6'd15: font = 8'h8E;  6'd16: font = 8'hC2;  6'd17: font = 8'h89;
            6'd18: font = 8'hCF;  6'd19: font = 8'hE1;  6'd20: font = 8'h8A;
            6'd21: font = 8'hC7;  6'd22: font = 8'hC8;  6'd23: font = 8'hAB;
            6'd24: font = 8'hA3;  6'd25: font = 8'h8C;  6'd26: font = 8'h98;
            6'd27: font = 8'hAF;  6'd28: font = 8'h92;  6'd29: font = 8'h87;
            6'd30: font = 8'hC1;  6'd31: font = 8'hE3;  6'd32: font = 8'h81;
            6'd33: font = 8'h89;  6'd34: font = 8'h91;  6'd35: font = 8'hA4;
            default: font = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/morse_char_buffer_char_to_seg.sv
// Combinational character-code to seven-segment glyph decoder (one per digit).
// Blanking of empty slots is done by the caller.
module char_to_seg
    import morse_pkg::*;
#(
    parameter int CODE_W = 6
) (
    input  logic [CODE_W-1:0] code,
    output logic [7:0]        seg
);

    always_comb begin
        seg = SEG_DASH;
        if (code == CODE_W'(CODE_ERR))
            seg = SEG_ERR;
        else if (code < CODE_W'(CODE_INVALID_LO))
            seg = font(code[5:0]);
    end

endmodule

// File: rtl/morse_char_buffer.sv
// Display character buffer: newest character in slot 0, edge-detected push and
// backspace, synchronous clear, scroll/block overflow policy, seven-segment output.
module morse_char_buffer
    import morse_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int CODE_W         = 6,
    parameter int SCROLL_DEFAULT = 1,
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [CODE_W-1:0]    push_code,
    input  logic                 backspace,
    input  logic                 clear,
    input  logic                 scroll_en,
    output logic [DEPTH*8-1:0]   seg_out,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);

    logic              push_q, bs_q, live_q;
    logic              push_ev, bs_ev, scroll_mode;
    logic [DEPTH-1:0]  valid_q, valid_nxt;
    logic [CODE_W-1:0] code_q   [DEPTH];
    logic [CODE_W-1:0] code_nxt [DEPTH];
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic              ovf_q, ovf_nxt;
    logic [7:0]        glyph [DEPTH];

    // live_q masks the first edge after reset so a level held through release is not an event
    assign push_ev     = push & ~push_q & live_q;
    assign bs_ev       = backspace & ~bs_q & live_q;
    assign scroll_mode = live_q ? scroll_en : (SCROLL_DEFAULT != 0);

    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign overflow = ovf_q;

    always_comb begin
        valid_nxt = valid_q;
        code_nxt  = code_q;
        count_nxt = count_q;
        ovf_nxt   = 1'b0;
        if (clear) begin
            valid_nxt = '0;
            count_nxt = '0;
        end else if (push_ev && bs_ev && !empty) begin
            code_nxt[0] = push_code;
        end else if (push_ev) begin
            if (full && !scroll_mode) begin
                ovf_nxt = 1'b1;
            end else begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    code_nxt[i]  = code_q[i-1];
                    valid_nxt[i] = valid_q[i-1];
                end
                code_nxt[0]  = push_code;
                valid_nxt[0] = 1'b1;
                if (!full)
                    count_nxt = count_q + 1'b1;
            end
        end else if (bs_ev && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                code_nxt[i]  = code_q[i+1];
                valid_nxt[i] = valid_q[i+1];
            end
            valid_nxt[DEPTH-1] = 1'b0;
            count_nxt          = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_q  <= 1'b0;
            bs_q    <= 1'b0;
            live_q  <= 1'b0;
            valid_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            push_q  <= push;
            bs_q    <= backspace;
            live_q  <= 1'b1;
            valid_q <= valid_nxt;
            count_q <= count_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

    // Codes carry no reset; an invalid slot is blanked regardless of its code.
    always_ff @(posedge clk) begin
        code_q <= code_nxt;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_digit
        char_to_seg #(.CODE_W(CODE_W)) u_dec (
            .code (code_q[g]),
            .seg  (glyph[g])
        );
        assign seg_out[g*8 +: 8] = valid_q[g] ? glyph[g] : SEG_BLANK;
    end

endmodule

// File: tb/tb_morse_char_buffer.sv
// Directed bench for morse_char_buffer (DEPTH = 8, CODE_W = 6).
module tb_morse_char_buffer;

    localparam int DEPTH  = 8;
    localparam int CODE_W = 6;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               push;
    logic [CODE_W-1:0]  push_code;
    logic               backspace;
    logic               clear;
    logic               scroll_en;
    logic [DEPTH*8-1:0] seg_out;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               overflow;

    int checks = 0;
    int errors = 0;

    morse_char_buffer #(.DEPTH(DEPTH), .CODE_W(CODE_W), .SCROLL_DEFAULT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_code (push_code),
        .backspace (backspace),
        .clear     (clear),
        .scroll_en (scroll_en),
        .seg_out   (seg_out),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [CODE_W-1:0] c);
        push_code = c;
        push      = 1'b1;
        tick();
        push      = 1'b0;
        tick();
    endtask

    task automatic do_bs();
        backspace = 1'b1;
        tick();
        backspace = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; push_code = '0; backspace = 1'b0;
        clear = 1'b0; scroll_en = 1'b1;
        tick(); tick();
        chk("rst_seg", seg_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick(); tick();

        // push 1,2,3
        do_push(1); do_push(2); do_push(3);
        chk("p123_seg", seg_out, 64'hFFFF_FFFF_FFF9_A4B0);
        chk("p123_count", count, 3);
        chk("p123_empty", empty, 0);

        clear = 1'b1; tick(); clear = 1'b0; tick();
        chk("clr_count", count, 0);

        // scroll: push 0..8
        scroll_en = 1'b1;
        for (int i = 0; i < 9; i++) do_push(CODE_W'(i));
        chk("scr_seg", seg_out, 64'hF9A4_B099_9282_F880);
        chk("scr_count", count, 8);
        chk("scr_full", full, 1);
        chk("scr_ovf", overflow, 0);

        // block: 9th push dropped
        scroll_en = 1'b0;
        push_code = 9; push = 1'b1;
        tick();
        chk("blk_ovf_hi", overflow, 1);
        chk("blk_seg", seg_out, 64'hF9A4_B099_9282_F880);
        chk("blk_count", count, 8);
        push = 1'b0;
        tick();
        chk("blk_ovf_lo", overflow, 0);

        do_bs();
        chk("bs_full_seg", seg_out, 64'hFFF9_A4B0_9992_82F8);
        chk("bs_full_count", count, 7);

        clear = 1'b1; tick(); clear = 1'b0; tick();
        do_push(1); do_push(2);

        // simultaneous push + backspace replaces slot 0
        push_code = 5; push = 1'b1; backspace = 1'b1;
        tick();
        chk("rep_seg", seg_out, 64'hFFFF_FFFF_FFFF_F992);
        chk("rep_count", count, 2);
        push = 1'b0; backspace = 1'b0;
        tick();

        backspace = 1'b1;
        repeat (10) tick();
        backspace = 1'b0;
        tick();
        chk("bshold_count", count, 1);
        chk("bshold_seg", seg_out, 64'hFFFF_FFFF_FFFF_FFF9);

        do_bs();
        do_bs();
        chk("bs_empty_count", count, 0);
        chk("bs_empty_flag", empty, 1);
        chk("bs_empty_seg", seg_out, 64'hFFFF_FFFF_FFFF_FFFF);

        // clear with a push edge in the same cycle
        do_push(4);
        push_code = 6; push = 1'b1; clear = 1'b1;
        tick();
        chk("clrpush_count", count, 0);
        chk("clrpush_seg", seg_out, 64'hFFFF_FFFF_FFFF_FFFF);
        push = 1'b0; clear = 1'b0;
        tick();
        chk("clrpush_after", count, 0);

        do_push(40); do_push(63);
        chk("dash_err_seg", seg_out, 64'hFFFF_FFFF_FFFF_BF86);
        do_push(10);
        chk("letter_a", seg_out[7:0], 8'h88);

        // async reset with push held high
        push_code = 7; push = 1'b1;
        tick();
        chk("pre_rst_count", count, 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_seg", seg_out, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("arst_empty", empty, 1);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("held_no_event", count, 0);
        push = 1'b0; tick();
        push = 1'b1; tick();
        chk("repush_count", count, 1);
        chk("repush_seg", seg_out[7:0], 8'hF8);
        push = 1'b0; tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_char_buffer.md
# morse_char_buffer

Parametrised display character buffer for the Morse decoder. It accepts decoded character codes from the decoder core or keypad, stores up to DEPTH characters newest-rightmost, and supports backspace, clear, and a selectable overflow policy (scroll or block). It drives the flattened seven-segment bus for the display scanner; this generation adds configurable depth and code width, edge-detected commands, occupancy status and overflow reporting.

## Interface
- DEPTH, 8: number of character slots/digits, 2..16.
- CODE_W, 6: character code width; codes 0–9 are digits, 10–35 are A–Z, 36–62 are invalid, 63 is the error glyph.
- SCROLL_DEFAULT, 1: overflow mode after reset; 1 = scroll, 0 = block.
- Reset is rst, asynchronous, active-high; the clock is clk.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- push  in  1  level; a rising edge enters push_code.
- push_code  in  CODE_W  code sampled on the push edge.
- backspace  in  1  level; a rising edge deletes the newest character.
- clear  in  1  synchronous clear, level, highest priority.
- scroll_en  in  1  overflow mode; it is sampled only when a push occurs while the buffer is full.
- seg_out  out  DEPTH*8  active-low segments {dp,g,f,e,d,c,b,a}; slot 0 = seg_out[7:0] = newest character.
- count  out  $clog2(DEPTH+1)  number of stored characters.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  one-cycle pulse when a push is dropped in block mode.

## Operation
- Edge detect: push_q and bs_q registers are 0 after reset.
  - push_ev = push & ~push_q.
  - bs_ev = backspace & ~bs_q.
  - Both events are combinational and act at the same clock edge.
- Storage: DEPTH slots, each holding {valid, code}. Slot 0 is the newest; valid slots are contiguous from slot 0.
- Command priority, evaluated once per clock edge:
  - clear: all slots invalid, count = 0. Any push or backspace edge in the same cycle is consumed and lost.
  - push_ev & bs_ev together: replace slot 0's code with push_code, count unchanged. If the buffer is empty, this acts as a normal push.
  - push_ev, not full: shift slots up by one, write slot 0 = push_code, count + 1.
  - push_ev, full, scroll_en = 1: shift up; slot DEPTH-1 is discarded, slot 0 = push_code, count unchanged.
  - push_ev, full, scroll_en = 0: storage is unchanged and overflow pulses high for one cycle.
  - bs_ev, not empty: shift slots down by one, slot DEPTH-1 becomes invalid, count − 1.
  - bs_ev while empty: no effect, no error.
- Glyph decode per slot:
  - Invalid slot: 8'hFF (blank).
  - Digits: '0' = C0, '1' = F9, '2' = A4, '3' = B0, '4' = 99, '5' = 92, '6' = 82, '7' = F8, '8' = 80, '9' = 90.
  - Letters 10–35: standard seven-segment font, with dp off in every glyph.
  - Codes 36–62: 8'hBF ('-').
  - Code 63: 8'h86 ('E').
- Reset: every slot is invalid, so seg_out is all 8'hFF. count = 0, empty = 1, full = 0, overflow = 0.
- An asynchronous reset asserted mid-operation discards all stored data immediately. A level held high across reset release produces no event until it falls and rises again.

## Timing
- All state is registered on posedge clk. seg_out, count, full and empty are combinational decodes of registered state and are valid in the cycle after the updating edge.
- Latency from a sampled rising edge on push or backspace to updated outputs is 1 clk.
- overflow is registered and is high for exactly the cycle after the dropped push.
- A held push or backspace level produces exactly one event.
- The minimum spacing between events on the same input is 2 cycles (high, then low).
- No handshake and no back-pressure: a push in block mode while full is lost and flagged by overflow.

## Structure
- Package morse_pkg holds:
  - the code constants CODE_ERR = 63 and CODE_INVALID_LO = 36;
  - the glyph constants SEG_BLANK = 8'hFF, SEG_DASH = 8'hBF, SEG_ERR = 8'h86.
- Sub-module char_to_seg: combinational CODE_W → 8-bit glyph decoder, instantiated DEPTH times with a generate loop. The blank override for invalid slots is applied in morse_char_buffer.
- The top level contains the edge detectors, the slot array with its shift-up/shift-down/replace muxing, the count register and the overflow register.

## Test plan
- Reset, then push codes 1, 2, 3 → seg_out[23:0] = {F9, A4, B0}, i.e. slot 0 = B0 ('3'); count = 3; upper slots FF.
- DEPTH = 8, push 9 characters with scroll_en = 1 → count = 8, full = 1. The first character is gone and slot 0 is the 9th.
- Repeat with scroll_en = 0 → the 9th push is ignored, overflow is high for 1 cycle, and storage is unchanged.
- Push and backspace rising in the same cycle with count = 2 → slot 0 replaced, count stays 2. Backspace held 10 cycles → exactly one deletion. Backspace while empty → no change.
- clear asserted together with a push edge → count = 0, all FF, and the push is not stored. Codes 40 and 63 → BF and 86.
- rst asserted mid-stream while push is held high → all outputs reach their reset values immediately. No push event occurs after release until push goes low and then high again.
